// File: rtl/mk14_bus_arbiter.sv
// MK14 system RAM arbiter: shares the RAM between the CPU core and one
// auxiliary requester by freezing the core, then replaying its address.
module mk14_bus_arbiter #(
  parameter int MAX_AUX_BURST  = 4,
  parameter int CORE_MIN_SLOTS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_in,
  output logic        core_en,
  input  logic [15:0] core_addr,
  input  logic        core_we,
  input  logic [7:0]  core_wdata,
  output logic [7:0]  core_rdata,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [15:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic        aux_ack,
  output logic [7:0]  aux_rdata,
  output logic        aux_rvalid,
  output logic [15:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic        busy
);

  localparam int BW = $clog2(MAX_AUX_BURST + 1);
  localparam int QW = $clog2(CORE_MIN_SLOTS + 1);
  localparam logic [BW-1:0] BMAX = BW'(MAX_AUX_BURST);
  localparam logic [QW-1:0] QMAX = QW'(CORE_MIN_SLOTS);

  localparam logic [1:0] S_CORE    = 2'd0;
  localparam logic [1:0] S_AUX     = 2'd1;
  localparam logic [1:0] S_RESTORE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] burst_q, burst_d;
  logic [QW-1:0] quota_q, quota_d;
  logic          rvalid_q, rvalid_d;
  logic          take;

  assign take = (state_q == S_CORE) & aux_req & ~core_we
              & (quota_q == QMAX);

  always_comb begin
    state_d   = state_q;
    burst_d   = burst_q;
    quota_d   = quota_q;
    rvalid_d  = 1'b0;
    core_en   = 1'b0;
    aux_ack   = 1'b0;
    ram_addr  = core_addr;
    ram_we    = 1'b0;
    ram_wdata = core_wdata;
    case (state_q)
      S_CORE: begin
        core_en = en_in & ~take;
        ram_we  = core_we;
        if (core_en && quota_q != QMAX)
          quota_d = quota_q + QW'(1);
        if (take) begin
          state_d = S_AUX;
          burst_d = '0;
        end
      end
      S_AUX: begin
        if (aux_req) begin
          aux_ack   = 1'b1;
          ram_addr  = aux_addr;
          ram_we    = aux_we;
          ram_wdata = aux_wdata;
          rvalid_d  = ~aux_we;
          burst_d   = burst_q + BW'(1);
          if (burst_d == BMAX)
            state_d = S_RESTORE;
        end else begin
          // Idle aux cycle doubles as the core-address replay slot
          state_d = S_CORE;
          quota_d = '0;
        end
      end
      S_RESTORE: begin
        state_d = S_CORE;
        quota_d = '0;
      end
      default: state_d = S_CORE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_CORE;
      burst_q  <= '0;
      quota_q  <= QMAX;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      quota_q  <= quota_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign busy       = (state_q != S_CORE);
  assign aux_rvalid = rvalid_q;
  assign aux_rdata  = ram_rdata;
  assign core_rdata = ram_rdata;

endmodule

// File: tb/tb_mk14_bus_arbiter.sv
// Directed bench for mk14_bus_arbiter: per-cycle vector table plus
// hand-written grant, burst and interleave sequences.
module tb_mk14_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n, en_in, core_en;
  logic [15:0] core_addr, aux_addr, ram_addr;
  logic        core_we, aux_req, aux_we, aux_ack, aux_rvalid;
  logic [7:0]  core_wdata, core_rdata, aux_wdata, aux_rdata;
  logic        ram_we, busy;
  logic [7:0]  ram_wdata, ram_rdata;

  logic [7:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mk14_bus_arbiter #(.MAX_AUX_BURST(4), .CORE_MIN_SLOTS(8)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .core_en(core_en),
    .core_addr(core_addr), .core_we(core_we),
    .core_wdata(core_wdata), .core_rdata(core_rdata),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr),
    .aux_wdata(aux_wdata), .aux_ack(aux_ack),
    .aux_rdata(aux_rdata), .aux_rvalid(aux_rvalid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  // Single-port synchronous RAM, read-before-write
  always @(posedge clk) begin
    ram_rdata <= mem[ram_addr];
    if (ram_we === 1'b1) mem[ram_addr] = ram_wdata;
  end

  typedef struct {
    logic        r, e, q, aw, cw;
    logic [15:0] caddr, aaddr;
    logic [7:0]  cwd, awd;
    logic        cen, ack, rv, bsy;
    logic [15:0] raddr;
    logic        rwe;
    logic [7:0]  rd;
  } vec_t;

  function automatic vec_t mk(
    input logic r, e, q, aw, cw,
    input logic [15:0] ca, aa,
    input logic [7:0] cwd, awd,
    input logic cen, ack, rv, bsy,
    input logic [15:0] ra,
    input logic rwe,
    input logic [7:0] rd);
    vec_t t;
    t.r = r; t.e = e; t.q = q; t.aw = aw; t.cw = cw;
    t.caddr = ca; t.aaddr = aa; t.cwd = cwd; t.awd = awd;
    t.cen = cen; t.ack = ack; t.rv = rv; t.bsy = bsy;
    t.raddr = ra; t.rwe = rwe; t.rd = rd;
    return t;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
    end
  endtask

  vec_t v[$];
  byte  q[$];

  initial begin
    int bad, acks, rvs, brun, maxb, gap, grants, ming;
    logic pa;
    logic [7:0] ev;
    bit done;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0F00] = 8'hA5;
    for (int i = 0; i < 10; i++) mem[16'h0E00 + i] = 8'(i) ^ 8'h5A;

    rst_n = 0; en_in = 1; core_addr = 0; core_we = 0; core_wdata = 0;
    aux_req = 0; aux_we = 0; aux_addr = 0; aux_wdata = 0;

    // r e q aw cw caddr aaddr cwd awd | cen ack rv bsy raddr rwe rd
    v.push_back(mk(1,1,0,0,0,16'h0010,16'h0000,8'h00,8'h00,
                   1,0,0,0,16'h0010,0,8'h00));
    v.push_back(mk(1,1,0,0,1,16'h0F20,16'h0000,8'h11,8'h00,
                   1,0,0,0,16'h0F20,1,8'h00));
    v.push_back(mk(1,1,0,0,0,16'h0011,16'h0000,8'h00,8'h00,
                   1,0,0,0,16'h0011,0,8'h00));
    v.push_back(mk(1,1,1,0,0,16'h0010,16'h0F00,8'h00,8'h00,
                   0,0,0,0,16'h0010,0,8'h00));
    v.push_back(mk(1,1,1,0,0,16'h0010,16'h0F00,8'h00,8'h00,
                   0,1,0,1,16'h0F00,0,8'h00));
    v.push_back(mk(1,1,0,0,0,16'h0010,16'h0F00,8'h00,8'h00,
                   0,0,1,1,16'h0010,0,8'hA5));
    v.push_back(mk(1,1,0,0,0,16'h0010,16'h0F00,8'h00,8'h00,
                   1,0,0,0,16'h0010,0,8'h00));
    for (int i = 0; i < 7; i++)
      v.push_back(mk(1,1,1,0,0,16'h0012,16'h0F00,8'h00,8'h00,
                     1,0,0,0,16'h0012,0,8'h00));
    v.push_back(mk(1,1,1,0,1,16'h0F20,16'h0F00,8'h3C,8'h00,
                   1,0,0,0,16'h0F20,1,8'h00));
    v.push_back(mk(1,1,1,1,0,16'h0021,16'h0F10,8'h00,8'h55,
                   0,0,0,0,16'h0021,0,8'h00));
    v.push_back(mk(1,1,1,1,0,16'h0021,16'h0F10,8'h00,8'h55,
                   0,1,0,1,16'h0F10,1,8'h00));
    v.push_back(mk(1,1,1,0,0,16'h0021,16'h0F20,8'h00,8'h00,
                   0,1,0,1,16'h0F20,0,8'h00));
    v.push_back(mk(0,1,1,0,0,16'h0021,16'h0F10,8'h00,8'h00,
                   0,1,1,1,16'h0F10,0,8'h3C));
    v.push_back(mk(1,1,1,0,0,16'h0030,16'h0F20,8'h00,8'h00,
                   0,0,0,0,16'h0030,0,8'h00));
    v.push_back(mk(1,1,1,0,0,16'h0030,16'h0F20,8'h00,8'h00,
                   0,1,0,1,16'h0F20,0,8'h00));
    v.push_back(mk(1,1,0,0,0,16'h0030,16'h0F20,8'h00,8'h00,
                   0,0,1,1,16'h0030,0,8'h3C));
    v.push_back(mk(1,1,0,0,0,16'h0030,16'h0F20,8'h00,8'h00,
                   1,0,0,0,16'h0030,0,8'h00));

    repeat (3) @(posedge clk);

    foreach (v[i]) begin
      @(posedge clk); #1;
      rst_n = v[i].r; en_in = v[i].e; aux_req = v[i].q;
      aux_we = v[i].aw; core_we = v[i].cw;
      core_addr = v[i].caddr; aux_addr = v[i].aaddr;
      core_wdata = v[i].cwd; aux_wdata = v[i].awd;
      @(negedge clk);
      chk("core_en", i, 16'(core_en), 16'(v[i].cen));
      chk("aux_ack", i, 16'(aux_ack), 16'(v[i].ack));
      chk("aux_rvalid", i, 16'(aux_rvalid), 16'(v[i].rv));
      chk("busy", i, 16'(busy), 16'(v[i].bsy));
      chk("ram_addr", i, ram_addr, v[i].raddr);
      chk("ram_we", i, 16'(ram_we), 16'(v[i].rwe));
      if (v[i].rv) chk("aux_rdata", i, 16'(aux_rdata), 16'(v[i].rd));
    end

    // en_in=0 freezes the core and must not refill the quota
    bad = 0;
    @(posedge clk); #1;
    en_in = 0; aux_req = 1; aux_we = 0; aux_addr = 16'h0F00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || core_en !== 1'b0 || aux_ack !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    chk("en_off_no_grant", 0, 16'(bad), 16'd0);
    en_in = 1; aux_req = 0;
    repeat (7) @(posedge clk);
    #1;

    // Aux write interleaved with a core load of the same byte
    core_addr = 16'h0F10; core_we = 0;
    aux_req = 1; aux_we = 1; aux_addr = 16'h0F10; aux_wdata = 8'h77;
    @(negedge clk);
    chk("t5_take_cen", 0, 16'(core_en), 16'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_ack", 0, 16'(aux_ack), 16'd1);
    chk("t5_ram_we", 0, 16'(ram_we), 16'd1);
    chk("t5_ram_addr", 0, ram_addr, 16'h0F10);
    @(posedge clk); #1;
    aux_req = 0; aux_we = 0;
    @(negedge clk);
    chk("t5_replay_addr", 0, ram_addr, 16'h0F10);
    chk("t5_replay_busy", 0, 16'(busy), 16'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_core_en", 0, 16'(core_en), 16'd1);
    chk("t5_core_rdata", 0, 16'(core_rdata), 16'h0077);

    // Long aux read stream split into bounded bursts
    @(posedge clk); #1;
    core_addr = 16'h0050; aux_req = 1; aux_we = 0; aux_addr = 16'h0E00;
    acks = 0; rvs = 0; brun = 0; maxb = 0; gap = 0;
    grants = 0; ming = 1000; pa = 0; done = 0;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (aux_rvalid) begin
        rvs++;
        ev = (q.size() > 0) ? q.pop_front() : 8'hXX;
        chk("t3_rdata", rvs, 16'(aux_rdata), 16'(ev));
      end
      if (aux_ack) begin
        if (!pa) begin
          if (grants > 0 && gap < ming) ming = gap;
          grants++; brun = 0; gap = 0;
        end
        brun++;
        if (brun > maxb) maxb = brun;
        acks++;
        q.push_back(mem[ram_addr]);
      end
      if (core_en) gap++;
      pa = aux_ack;
      if (acks >= 10 && rvs >= 10 && !busy) done = 1;
      @(posedge clk); #1;
      if (acks >= 10) aux_req = 0;
      else aux_addr = 16'h0E00 + 16'(acks);
    end
    chk("t3_acks", 0, 16'(acks), 16'd10);
    chk("t3_rvalids", 0, 16'(rvs), 16'd10);
    chk("t3_max_burst", 0, 16'(maxb), 16'd4);
    chk("t3_grants", 0, 16'(grants), 16'd3);
    chk("t3_min_gap", 0, 16'(ming), 16'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
